lut_loader: RTL

- Runtime writer for the inferred-RAM lookup tables used by the residue arithmetic datapath.
- Owns a DEPTH x DW memory and fills a contiguous, wrap-around address window from a valid/ready word stream.
- After the fill, reads the window back through the same registered-address, registered-data read path the datapath uses, and compares XOR checksums.
- Outside a load, it serves ordinary 2-cycle-latency lookups.

---
 rtl/lut_loader.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/lut_loader.sv
// Runtime loader for a DEPTH x DW lookup table: fills a wrap-around window from a
// valid/ready stream, verifies it by XOR-checksum readback, and serves 2-cycle lookups.
module lut_loader #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          busy,
  output logic          done,
  output logic          verify_err,
  input  logic [AW-1:0] lu_addr,
  output logic [DW-1:0] lu_data
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] ONE_C = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_VERIFY = 3'd2,
    S_DRAIN  = 3'd3,
    S_CHECK  = 3'd4
  } state_e;

  function automatic logic [DW-1:0] csum_fold(input logic [DW-1:0] acc, input logic [DW-1:0] word);
    return acc ^ word;
  endfunction

  state_e        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   rem_q, rem_d;
  logic [DW-1:0] wr_csum_q, wr_csum_d;
  logic [DW-1:0] rd_csum_q, rd_csum_d;
  logic [DW-1:0] lu_data_q, lu_data_d;
  logic          drain_q, drain_d;
  logic          rv1_q, rv1_d;
  logic          rv2_q, rv2_d;
  logic          wr_ready_q, wr_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          verr_q, verr_d;
  logic          accept_s;

  logic [DW-1:0] mem_q [DEPTH];

  assign accept_s   = wr_valid && wr_ready_q && (state_q == S_LOAD);
  assign wr_ready   = wr_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign verify_err = verr_q;
  assign lu_data    = lu_data_q;

  // Table storage: written only by accepted load words, never reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[ptr_q] <= wr_data;
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    wr_csum_d  = wr_csum_q;
    verr_d     = verr_q;
    done_d     = 1'b0;
    drain_d    = 1'b0;
    // rv1/rv2 track which registered read-data samples belong to the verify pass
    rv1_d      = (state_q == S_VERIFY);
    rv2_d      = rv1_q;
    raddr_d    = (state_q == S_VERIFY) ? ptr_q : lu_addr;
    lu_data_d  = mem_q[raddr_q];
    if (rv2_q) begin
      rd_csum_d = csum_fold(rd_csum_q, lu_data_q);
    end else begin
      rd_csum_d = rd_csum_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          verr_d = 1'b0;
          if (count != '0) begin
            base_d    = base_addr;
            count_d   = count;
            ptr_d     = base_addr;
            rem_d     = count;
            wr_csum_d = '0;
            rd_csum_d = '0;
            state_d   = S_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (accept_s) begin
          wr_csum_d = csum_fold(wr_csum_q, wr_data);
          if (rem_q == ONE_C) begin
            ptr_d   = base_q;
            rem_d   = count_q;
            state_d = S_VERIFY;
          end else begin
            ptr_d = ptr_q + AW'(1);
            rem_d = rem_q - ONE_C;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_VERIFY: begin
        ptr_d = ptr_q + AW'(1);
        rem_d = rem_q - ONE_C;
        if (rem_q == ONE_C) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_VERIFY;
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          // rd_csum_d already holds the final readback fold at this edge
          verr_d  = (wr_csum_q != rd_csum_d);
          done_d  = 1'b1;
          state_d = S_CHECK;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    wr_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      ptr_q      <= '0;
      rem_q      <= '0;
      raddr_q    <= '0;
      wr_csum_q  <= '0;
      rd_csum_q  <= '0;
      lu_data_q  <= '0;
      drain_q    <= 1'b0;
      rv1_q      <= 1'b0;
      rv2_q      <= 1'b0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      verr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      raddr_q    <= raddr_d;
      wr_csum_q  <= wr_csum_d;
      rd_csum_q  <= rd_csum_d;
      lu_data_q  <= lu_data_d;
      drain_q    <= drain_d;
      rv1_q      <= rv1_d;
      rv2_q      <= rv2_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      verr_q     <= verr_d;
    end
  end

endmodule
